// File: rtl/hazard_exception_ctrl_if.sv
// Pipeline <-> sequencer bundle for the 5-stage 8-bit MIPS core.
// The pipeline side (master) reports hazard/exception sources and receives
// the steering controls; the sequencer side (slave) does the reverse.
interface hazard_exception_ctrl_if;
    // Hazard and exception sources from the pipeline
    logic       IDEX_MemRead;
    logic [2:0] IDEX_RegisterRt;
    logic [2:0] IFID_RegisterRs;
    logic [2:0] IFID_RegisterRt;
    logic [5:0] IFID_PC;
    logic [5:0] IDEX_PC;
    logic       IllegalOp;
    logic       EretID;
    logic       BranchTaken;
    logic       Overflow;

    // Steering controls and exception state back to the pipeline
    logic       PCWrite;
    logic       IFID_Write;
    logic       IFID_Flush;
    logic       IDEX_Flush;
    logic       EXMEM_Flush;
    logic [1:0] PCSel;
    logic [2:0] ExceptionCause;
    logic [5:0] ExceptionPC;
    logic       ExcPending;
    logic [7:0] StallCount;

    modport master (
        output IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
               IFID_PC, IDEX_PC, IllegalOp, EretID, BranchTaken, Overflow,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSel,
               ExceptionCause, ExceptionPC, ExcPending, StallCount
    );

    modport slave (
        input  IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
               IFID_PC, IDEX_PC, IllegalOp, EretID, BranchTaken, Overflow,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSel,
               ExceptionCause, ExceptionPC, ExcPending, StallCount
    );
endinterface

// File: rtl/hazard_exception_ctrl.sv
// Central pipeline sequencer: load-use stalls, taken-branch squash and the
// precise-exception entry/return sequence. Steering outputs are combinational
// from inputs and state; cause, EPC and the stall counter are registered.
module hazard_exception_ctrl #(
    parameter logic [5:0] HANDLER_ADDR = 6'd60,
    parameter logic [2:0] CAUSE_OVF    = 3'b001,
    parameter logic [2:0] CAUSE_ILL    = 3'b010,
    parameter logic [2:0] CAUSE_DBL    = 3'b111
) (
    input  logic                     clk,
    input  logic                     rst,
    hazard_exception_ctrl_if.slave   bus
);

    // The datapath muxes HANDLER_ADDR in on PCSel=10; a handler at 0 would
    // alias the reset vector and make entry indistinguishable from reset.
    if (HANDLER_ADDR == 6'd0) begin : g_bad_handler
        $error("HANDLER_ADDR must not alias the reset vector");
    end

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_RETURN  = 2'd2
    } state_t;

    localparam logic [1:0] SEL_SEQ     = 2'b00;
    localparam logic [1:0] SEL_BRANCH  = 2'b01;
    localparam logic [1:0] SEL_HANDLER = 2'b10;
    localparam logic [1:0] SEL_EPC     = 2'b11;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] cause_r;
    logic [2:0] cause_nxt_s;
    logic [5:0] epc_r;
    logic [5:0] epc_nxt_s;
    logic [7:0] stall_cnt_r;
    logic       stall_inc_s;
    logic       load_use_s;

    logic       pc_write_s;
    logic       ifid_write_s;
    logic       ifid_flush_s;
    logic       idex_flush_s;
    logic       exmem_flush_s;
    logic [1:0] pc_sel_s;

    // Load-use hit: a load in EX writes a register the instruction in ID reads (r0 never hazards)
    always_comb begin
        load_use_s = 1'b0;
        if (bus.IDEX_MemRead && (bus.IDEX_RegisterRt != 3'd0) &&
            ((bus.IDEX_RegisterRt == bus.IFID_RegisterRs) ||
             (bus.IDEX_RegisterRt == bus.IFID_RegisterRt))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Prioritised event decode: steering outputs plus next state / cause / EPC
    always_comb begin
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        pc_sel_s      = SEL_SEQ;
        state_nxt_s   = state_r;
        cause_nxt_s   = cause_r;
        epc_nxt_s     = epc_r;
        stall_inc_s   = 1'b0;

        if (rst) begin
            // Hold the front end frozen and every stage drained while in reset
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
            pc_sel_s      = SEL_SEQ;
            state_nxt_s   = ST_RUN;
        end else if (bus.Overflow) begin
            // Oldest faulting instruction is in EX: also kill its EX/MEM write
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
            pc_sel_s      = SEL_HANDLER;
            state_nxt_s   = ST_PENDING;
            if (state_r == ST_PENDING) begin
                cause_nxt_s = CAUSE_DBL;
            end else begin
                cause_nxt_s = CAUSE_OVF;
                epc_nxt_s   = bus.IDEX_PC;
            end
        end else if (bus.IllegalOp) begin
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            pc_sel_s      = SEL_HANDLER;
            state_nxt_s   = ST_PENDING;
            if (state_r == ST_PENDING) begin
                cause_nxt_s = CAUSE_DBL;
            end else begin
                cause_nxt_s = CAUSE_ILL;
                epc_nxt_s   = bus.IFID_PC;
            end
        end else if (state_r == ST_RETURN) begin
            // Single return cycle: refetch from EPC, drop the younger wrong-path work
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            pc_sel_s      = SEL_EPC;
            cause_nxt_s   = 3'd0;
            state_nxt_s   = ST_RUN;
        end else if (bus.BranchTaken) begin
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            pc_sel_s      = SEL_BRANCH;
        end else if (bus.EretID && (state_r == ST_PENDING)) begin
            state_nxt_s   = ST_RETURN;
        end else if (load_use_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_flush_s  = 1'b1;
            stall_inc_s   = 1'b1;
        end else begin
            state_nxt_s   = state_r;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            case (state_nxt_s)
                ST_RUN, ST_PENDING, ST_RETURN: state_r <= state_nxt_s;
                default:                       state_r <= ST_RUN;
            endcase
        end
    end

    // Latched exception cause and EPC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_r <= 3'd0;
            epc_r   <= 6'd0;
        end else begin
            cause_r <= cause_nxt_s;
            epc_r   <= epc_nxt_s;
        end
    end

    // Saturating load-use stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 8'd0;
        end else if (stall_inc_s && (stall_cnt_r != 8'hFF)) begin
            stall_cnt_r <= stall_cnt_r + 8'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.PCWrite        = pc_write_s;
    assign bus.IFID_Write     = ifid_write_s;
    assign bus.IFID_Flush     = ifid_flush_s;
    assign bus.IDEX_Flush     = idex_flush_s;
    assign bus.EXMEM_Flush    = exmem_flush_s;
    assign bus.PCSel          = pc_sel_s;
    assign bus.ExceptionCause = cause_r;
    assign bus.ExceptionPC    = epc_r;
    assign bus.ExcPending     = (state_r == ST_PENDING);
    assign bus.StallCount     = stall_cnt_r;

endmodule
